// File: rtl/weight_load_sequencer.sv
// ---------------------------------------------------------------------------
// weight_load_sequencer
//
// Sequences weight loading for the MAC array, one output channel per pass:
//   WRITE   - accept N weight beats from the AXIS FIFO into BRAM (addr 0..N-1)
//   PRELOAD - read BRAM back, shifting each returned word into the preload regs
//   LOAD    - one-cycle commit of the preload regs to the active weights
//   WAIT    - hold until the compute pass for this output channel finishes
// N = K*K*Cin words per pass, Cout passes per layer.
//
// Optional build macro:
//   WLS_PERF_CNT_EN - adds perf_cycles[31:0], a saturating count of busy
//                     cycles, cleared when a start is taken in IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle pulse in IDLE: latch config and begin layer
//   abort                 synchronous return to IDLE from any state
//   kernel_size           K
//   input_channel_size    Cin
//   output_channel_size   Cout (number of passes)
//   wbeat_valid/ready     weight beat handshake (see below)
//   bram_write_en         write the accepted beat at bram_addr
//   bram_read_en          read bram_addr
//   bram_addr             shared BRAM address
//   bram_rdata_valid      read data valid, one cycle after bram_read_en
//   load_weight_preload   shift the returned BRAM word into the preload regs
//   load_weight           commit pulse
//   compute_done          current output channel's compute finished
//   write_weight_finish   pulse alongside each load_weight
//   layer_finish          pulse the cycle after the last pass (or a bad config)
//   busy                  sequencer not idle
//   cfg_err               sticky; set by a start with an unusable config
//
// Handshake: a beat is transferred in every cycle where wbeat_valid and
// wbeat_ready are both 1. wbeat_ready is 1 for the whole of WRITE and never
// depends on wbeat_valid; the source must hold a beat until it is taken.
//
// Assumes MAC_NUM <= 2**BRAM_ADDRESS_WIDTH so every legal N-1 fits bram_addr.
// ---------------------------------------------------------------------------
module weight_load_sequencer #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int CH_W               = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [4:0]                    kernel_size,
    input  logic [CH_W-1:0]               input_channel_size,
    input  logic [CH_W-1:0]               output_channel_size,
    input  logic                          wbeat_valid,
    output logic                          wbeat_ready,
    output logic                          bram_write_en,
    output logic                          bram_read_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    input  logic                          bram_rdata_valid,
    output logic                          load_weight_preload,
    output logic                          load_weight,
    input  logic                          compute_done,
    output logic                          write_weight_finish,
    output logic                          layer_finish,
    output logic                          busy,
    output logic                          cfg_err
`ifdef WLS_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int BAW = BRAM_ADDRESS_WIDTH;
    // K*K needs 10 bits; times Cin gives the full, untruncated word count.
    localparam int NW  = 10 + CH_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_PRELOAD = 3'd2,
        S_LOAD    = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [9:0]      k_sq;
    logic [NW-1:0]   n_full;
    logic            cfg_bad;
    logic [BAW-1:0]  n_last;      // N-1 of the running layer
    logic [CH_W-1:0] cout_last;   // Cout-1 of the running layer
    logic [BAW-1:0]  addr;
    logic            rd_done;     // all N reads of this PRELOAD issued
    logic [BAW-1:0]  rx_cnt;      // read words returned so far in PRELOAD
    logic [CH_W-1:0] pass;
    logic            layer_finish_q;
    logic            cfg_err_q;
    logic            start_ok, start_bad, last_pass;

    assign k_sq    = {5'd0, kernel_size} * {5'd0, kernel_size};
    assign n_full  = NW'(k_sq) * NW'(input_channel_size);
    assign cfg_bad = (n_full == '0) || (n_full > NW'(MAC_NUM)) ||
                     (output_channel_size == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next          = state;
        wbeat_ready         = 1'b0;
        bram_write_en       = 1'b0;
        bram_read_en        = 1'b0;
        load_weight_preload = 1'b0;
        load_weight         = 1'b0;
        write_weight_finish = 1'b0;
        start_ok            = 1'b0;
        start_bad           = 1'b0;
        last_pass           = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wbeat_ready   = 1'b1;
                bram_write_en = wbeat_valid;
                if (wbeat_valid && (addr == n_last)) state_next = S_PRELOAD;
            end
            S_PRELOAD: begin
                bram_read_en        = !rd_done;
                load_weight_preload = bram_rdata_valid;
                if (bram_rdata_valid && (rx_cnt == n_last)) state_next = S_LOAD;
            end
            S_LOAD: begin
                load_weight         = 1'b1;
                write_weight_finish = 1'b1;
                state_next          = S_WAIT;
            end
            S_WAIT: begin
                if (compute_done) begin
                    if (pass == cout_last) begin
                        last_pass  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Abort overrides everything, including a start or a final pass.
        if (abort) begin
            state_next = S_IDLE;
            start_ok   = 1'b0;
            start_bad  = 1'b0;
            last_pass  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_last         <= '0;
            cout_last      <= '0;
            addr           <= '0;
            rd_done        <= 1'b0;
            rx_cnt         <= '0;
            pass           <= '0;
            layer_finish_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else if (abort) begin
            addr           <= '0;
            rd_done        <= 1'b0;
            rx_cnt         <= '0;
            pass           <= '0;
            layer_finish_q <= 1'b0;
        end else begin
            layer_finish_q <= start_bad || last_pass;
            if (start_ok || start_bad) cfg_err_q <= start_bad;
            if (start_ok) begin
                n_last    <= BAW'(n_full - 1'b1);
                cout_last <= output_channel_size - 1'b1;
                addr      <= '0;
                pass      <= '0;
            end
            case (state)
                S_WRITE: begin
                    if (bram_write_en) addr <= (addr == n_last) ? '0 : addr + 1'b1;
                end
                S_PRELOAD: begin
                    // Address parks on N-1 after the last read instead of wrapping.
                    if (bram_read_en) begin
                        if (addr == n_last) rd_done <= 1'b1;
                        else                addr    <= addr + 1'b1;
                    end
                    if (bram_rdata_valid) rx_cnt <= rx_cnt + 1'b1;
                    if (state_next == S_LOAD) begin
                        addr    <= '0;
                        rd_done <= 1'b0;
                        rx_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (compute_done) pass <= last_pass ? '0 : pass + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bram_addr    = addr;
    assign busy         = (state != S_IDLE);
    assign layer_finish = layer_finish_q;
    assign cfg_err      = cfg_err_q;

`ifdef WLS_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          perf_q <= '0;
        else if (start_ok || start_bad)                      perf_q <= '0;
        else if (busy && (perf_q != 32'hFFFF_FFFF))          perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Testbench for weight_load_sequencer. Expected behaviour comes from the
// layer arithmetic: N = K*K*Cin words per pass, Cout passes, addresses
// 0..N-1 per pass, back-to-back pass latency 2N+2 cycles to load_weight.
module tb_weight_load_sequencer;

    localparam int BAW  = 12;
    localparam int CH_W = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort;
    logic [4:0]      kernel_size;
    logic [CH_W-1:0] input_channel_size, output_channel_size;
    logic            wbeat_valid, wbeat_ready;
    logic            bram_write_en, bram_read_en;
    logic [BAW-1:0]  bram_addr;
    logic            bram_rdata_valid = 1'b0;
    logic            load_weight_preload, load_weight;
    logic            compute_done;
    logic            write_weight_finish, layer_finish, busy, cfg_err;
`ifdef WLS_PERF_CNT_EN
    logic [31:0]     perf_cycles;
`endif

    weight_load_sequencer #(.MAC_NUM(256), .BRAM_ADDRESS_WIDTH(BAW), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .kernel_size(kernel_size), .input_channel_size(input_channel_size),
        .output_channel_size(output_channel_size),
        .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready),
        .bram_write_en(bram_write_en), .bram_read_en(bram_read_en),
        .bram_addr(bram_addr), .bram_rdata_valid(bram_rdata_valid),
        .load_weight_preload(load_weight_preload), .load_weight(load_weight),
        .compute_done(compute_done), .write_weight_finish(write_weight_finish),
        .layer_finish(layer_finish), .busy(busy), .cfg_err(cfg_err)
`ifdef WLS_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // ---------------- clock / BRAM read latency model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) bram_rdata_valid <= bram_read_en;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, start_cyc = 0, first_lw_cyc = 0;
    int wr_cnt, rd_cnt, pre_cnt, lw_cnt, wwf_cnt, lf_cnt, busy_cyc;
    int cur_n  = 1;
    int vmode  = 0;   // 0: valid always, 1: toggle, 2: random

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; pre_cnt = 0; lw_cnt = 0;
        wwf_cnt = 0; lf_cnt = 0; busy_cyc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (start && !busy) start_cyc = cyc;
            if (bram_write_en || bram_read_en)
                check("wr_rd_exclusive", 32'(bram_write_en & bram_read_en), 32'd0);
            if (bram_write_en) begin
                check("wr_addr", 32'(bram_addr), 32'(wr_cnt % cur_n));
                wr_cnt++;
            end
            if (bram_read_en) begin
                check("rd_addr", 32'(bram_addr), 32'(rd_cnt % cur_n));
                rd_cnt++;
            end
            if (load_weight_preload) pre_cnt++;
            if (load_weight) begin
                check("wwf_with_load", 32'(write_weight_finish), 32'd1);
                if (lw_cnt == 0) first_lw_cyc = cyc;
                lw_cnt++;
            end
            if (write_weight_finish) wwf_cnt++;
            if (layer_finish) lf_cnt++;
            if (busy) busy_cyc++;
        end
    end

    // Weight beat source.
    initial begin
        wbeat_valid = 1'b0;
        forever begin
            tick();
            case (vmode)
                0:       wbeat_valid = 1'b1;
                1:       wbeat_valid = ~wbeat_valid;
                default: wbeat_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [31:0] strobes();
        return {24'd0, wbeat_ready, bram_write_en, bram_read_en, load_weight_preload,
                load_weight, write_weight_finish, layer_finish, busy};
    endfunction

    task automatic pulse_start(input int k, input int cin, input int cout);
        kernel_size         = 5'(k);
        input_channel_size  = CH_W'(cin);
        output_channel_size = CH_W'(cout);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_count(input string tag, ref int cnt, input int target, input int budget);
        int t = 0;
        while (cnt < target && t < budget) begin tick(); t++; end
        check(tag, 32'(cnt), 32'(target));
    endtask

    // One full layer with a compute_done delay of dly cycles after each LOAD.
    task automatic run_layer(input int k, input int cin, input int cout,
                             input int vm, input int dly, input bit spurious);
        int n;
        n = k * k * cin;
        clear_counts();
        cur_n = n;
        vmode = vm;
        pulse_start(k, cin, cout);
        check("cfg_err_cleared", 32'(cfg_err), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        if (spurious) begin
            // compute_done and start outside WAIT/IDLE must be ignored
            compute_done = 1'b1; start = 1'b1;
            tick();
            compute_done = 1'b0; start = 1'b0;
        end
        for (int p = 0; p < cout; p++) begin
            wait_count("pass_loaded", wwf_cnt, p + 1, 6000);
            check("no_early_layer_finish", 32'(lf_cnt), 32'd0);
            repeat (dly) tick();
            compute_done = 1'b1;
            tick();
            compute_done = 1'b0;
        end
        repeat (3) tick();
        check("layer_finish_count", 32'(lf_cnt), 32'd1);
        check("idle_after_layer", 32'(busy), 32'd0);
        check("write_count", 32'(wr_cnt), 32'(n * cout));
        check("read_count", 32'(rd_cnt), 32'(n * cout));
        check("preload_count", 32'(pre_cnt), 32'(n * cout));
        check("load_count", 32'(lw_cnt), 32'(cout));
        check("wwf_count", 32'(wwf_cnt), 32'(cout));
        if (vm == 0) begin
            check("first_load_latency", 32'(first_lw_cyc - start_cyc), 32'(2 * n + 2));
            check("busy_cycles", 32'(busy_cyc), 32'(cout * (2 * n + 3 + dly)));
        end
    endtask

    task automatic run_bad(input int k, input int cin, input int cout);
        clear_counts();
        cur_n = 1;
        pulse_start(k, cin, cout);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        check("bad_layer_finish", 32'(layer_finish), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("bad_single_finish", 32'(lf_cnt), 32'd1);
        check("bad_no_bram", 32'(wr_cnt + rd_cnt), 32'd0);
        check("bad_cfg_err_sticky", 32'(cfg_err), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; compute_done = 1'b0;
        kernel_size = '0; input_channel_size = '0; output_channel_size = '0;
        #1;
        check("reset_strobes", strobes(), 32'd0);
        check("reset_addr", 32'(bram_addr), 32'd0);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset_strobes", strobes(), 32'd0);

        // Directed layers
        run_layer(3, 4, 1, 0, 2, 1'b0);   // N=36, back-to-back, load at +74
        run_layer(1, 2, 3, 0, 5, 1'b0);   // 3 passes, compute_done 5 cycles late
        run_layer(2, 3, 2, 1, 1, 1'b1);   // toggling valid, spurious strobes

        // Unusable configurations, then a valid start clears cfg_err
        run_bad(17, 1, 1);                 // N=289
        run_bad(1, 257, 1);                // N=257, just over the limit
        run_bad(2, 0, 3);                  // N=0
        run_bad(1, 1, 0);                  // Cout=0
        run_layer(16, 1, 1, 0, 0, 1'b0);   // N=256, largest legal pass

        // Abort mid-PRELOAD
        clear_counts();
        cur_n = 16; vmode = 0;
        pulse_start(2, 4, 2);
        wait_count("reach_preload", pre_cnt, 5, 200);
        check("abort_read_active", 32'(bram_read_en), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_strobes", strobes(), 32'd0);
        check("abort_addr", 32'(bram_addr), 32'd0);
        repeat (5) tick();
        check("abort_no_finish", 32'(lf_cnt + wwf_cnt), 32'd0);

        // Reset mid-WRITE
        clear_counts();
        pulse_start(2, 4, 2);
        wait_count("reach_write", wr_cnt, 3, 200);
        rst_n = 1'b0;
        #1;
        check("reset_mid_strobes", strobes(), 32'd0);
        check("reset_mid_addr", 32'(bram_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_layer(1, 3, 2, 2, 3, 1'b0);

        // Randomised layers
        for (int i = 0; i < 6; i++) begin
            run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                      int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

`ifdef WLS_PERF_CNT_EN
        run_layer(1, 1, 1, 0, 0, 1'b0);
        check("perf_vs_busy", perf_cycles, 32'(busy_cyc));
        check("perf_value", perf_cycles, 32'd5);
        repeat (4) tick();
        check("perf_holds_idle", perf_cycles, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
